// File: rtl/texture_mapper_stream_fifo.sv
// Stream FIFO: dual-port RAM storage, RD_LATENCY read pipe, FWFT prefetch.
// Define TEXTURE_MAPPER_FIFO_STATS_EN to add the max_count high-water port.
module texture_mapper_stream_fifo #(
    parameter int    WIDTH      = 32,
    parameter int    DEPTH      = 512,
    parameter int    RD_LATENCY = 1,
    parameter int    AF_THRESH  = DEPTH - 4,
    parameter int    AE_THRESH  = 4,
    parameter string RAMSTYLE   = ""
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef TEXTURE_MAPPER_FIFO_STATS_EN
    output logic [$clog2(DEPTH+1)-1:0] max_count,
`endif
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int L   = RD_LATENCY;
    localparam int PF  = RD_LATENCY + 1;
    localparam int PW  = $clog2(PF);
    localparam int PCW = $clog2(PF + 1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    ram_cnt;
    logic [CW-1:0]    count_next;

    logic [L-1:0]     rd_vld;
    logic [WIDTH-1:0] rd_pipe [L];
    logic [PCW-1:0]   in_flight;

    logic [WIDTH-1:0] pf_mem [PF];
    logic [PW-1:0]    pf_rd;
    logic [PW-1:0]    pf_wr;
    logic [PCW-1:0]   pf_cnt;
    logic [PCW-1:0]   pf_free;

    logic             flush;
    logic             push;
    logic             pop;
    logic             issue;
    logic             land;

    function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
        return (p == PW'(PF - 1)) ? '0 : p + 1'b1;
    endfunction

    assign flush     = reset | clear;
    assign in_ready  = !reset && !clear && (count < CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign out_valid = (pf_cnt != '0);
    assign out_data  = pf_mem[pf_rd];
    assign pop       = out_valid & out_ready;
    assign land      = rd_vld[L-1];

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < L; i++) begin
            in_flight = in_flight + PCW'(rd_vld[i]);
        end
    end

    // A slot freed by this cycle's pop counts, so streaming has no bubbles.
    always_comb begin
        pf_free = PCW'(PF) - pf_cnt + PCW'(pop);
        issue   = (ram_cnt != '0) && (pf_free > in_flight);
    end

    assign count_next = count + CW'(push) - CW'(pop);

    generate
        if (RAMSTYLE == "") begin : g_ram_plain
            logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                end
                if (issue) begin
                    rd_pipe[0] <= mem[rd_ptr];
                end
                for (int i = 1; i < L; i++) begin
                    rd_pipe[i] <= rd_pipe[i-1];
                end
            end
        end else begin : g_ram_styled
            (* ramstyle = RAMSTYLE, ram_style = RAMSTYLE *)
            logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                end
                if (issue) begin
                    rd_pipe[0] <= mem[rd_ptr];
                end
                for (int i = 1; i < L; i++) begin
                    rd_pipe[i] <= rd_pipe[i-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (land) begin
            pf_mem[pf_wr] <= rd_pipe[L-1];
        end
    end

    // Dropping rd_vld on flush kills in-flight reads; their data never lands.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            rd_vld  <= '0;
            pf_rd   <= '0;
            pf_wr   <= '0;
            pf_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt   <= ram_cnt + CW'(push) - CW'(issue);
            rd_vld[0] <= issue;
            for (int i = 1; i < L; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end
            if (land) begin
                pf_wr <= pf_inc(pf_wr);
            end
            if (pop) begin
                pf_rd <= pf_inc(pf_rd);
            end
            pf_cnt <= pf_cnt + PCW'(land) - PCW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            almost_full  <= (count_next >= CW'(AF_THRESH));
            almost_empty <= (count_next <= CW'(AE_THRESH));
        end
    end

`ifdef TEXTURE_MAPPER_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (flush) begin
            max_count <= '0;
        end else if (count_next > max_count) begin
            max_count <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_texture_mapper_stream_fifo.sv
// Directed bench for texture_mapper_stream_fifo (DEPTH=16, RD_LATENCY=2).
// Covers latency, full/refusal, streaming, random backpressure, flush, stats.
module tb_texture_mapper_stream_fifo;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int L  = 2;
    localparam int AF = 12;
    localparam int AE = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
`ifdef TEXTURE_MAPPER_FIFO_STATS_EN
    logic [CW-1:0] max_count;
`endif

    int checks = 0;
    int passed = 0;

    texture_mapper_stream_fifo #(
        .WIDTH(W), .DEPTH(D), .RD_LATENCY(L),
        .AF_THRESH(AF), .AE_THRESH(AE), .RAMSTYLE("")
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
`ifdef TEXTURE_MAPPER_FIFO_STATS_EN
        .max_count(max_count),
`endif
        .almost_full(almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_one(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one(input string tag, input logic [W-1:0] exp);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_wait"}, 32'(n < 20), 32'd1);
        chk(tag, out_data, exp);
        step();
        out_ready = 1'b0;
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] held;
    logic [W-1:0] exp_d;
    logic         hold;
    int           pushed;
    int           cyc;

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Latency: push at edge t, out_valid after t+3.
        push_one(32'hA5);
        chk("lat_t0_valid", 32'(out_valid), 32'd0);
        chk("lat_t0_count", 32'(count), 32'd1);
        step();
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_t2_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_t3_valid", 32'(out_valid), 32'd1);
        chk("lat_t3_data", out_data, 32'hA5);
        chk("lat_t3_count", 32'(count), 32'd1);
        chk("lat_t3_ae", 32'(almost_empty), 32'd1);
        pop_one("lat_pop", 32'hA5);
        chk("lat_after_count", 32'(count), 32'd0);

        // Fill to full, refuse 17th, pop one then accept.
        for (int i = 0; i < D; i++) begin
            chk("fill_ready", 32'(in_ready), 32'd1);
            push_one(W'(i));
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'((i + 1) >= AF));
            chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= AE));
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data = 32'h99;
        step();
        chk("refuse_count", 32'(count), 32'd16);
        chk("refuse_ready", 32'(in_ready), 32'd0);
        in_data = 32'h77;
        out_ready = 1'b1;
        chk("full_head", out_data, 32'd0);
        step();
        out_ready = 1'b0;
        chk("popfull_count", 32'(count), 32'd15);
        chk("popfull_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd16);
        chk("refill_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k < D; k++) begin
            pop_one("drain", W'(k));
        end
        pop_one("drain_last", 32'h77);
        chk("drain_count", 32'(count), 32'd0);

        // Streaming: one push and one pop every cycle after priming.
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            in_data = 32'h1000 + W'(c);
            if (c >= L + 2) begin
                chk("strm_valid", 32'(out_valid), 32'd1);
                chk("strm_data", out_data, 32'h1000 + W'(c - L - 2));
                chk("strm_count", 32'(count), 32'd4);
            end
            step();
        end
        in_valid = 1'b0;
        for (int k = 196; k < 200; k++) begin
            pop_one("strm_tail", 32'h1000 + W'(k));
        end
        chk("strm_end_count", 32'(count), 32'd0);

        // Random backpressure with scoreboard across many wraps.
        pushed = 0;
        cyc = 0;
        hold = 1'b0;
        held = '0;
        while ((pushed < 10000 || q.size() != 0) && cyc < 80000) begin
            if (hold) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_data", out_data, held);
            end
            in_valid = (pushed < 10000) && ($urandom_range(0, 1) == 1);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                if (q.size() != 0) exp_d = q.pop_front();
                else exp_d = 32'hDEADBEEF;
                chk("bp_data", out_data, exp_d);
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                pushed++;
            end
            hold = out_valid && !out_ready;
            held = out_data;
            step();
            cyc++;
            chk("bp_count", 32'(count), 32'(q.size()));
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_done", 32'(pushed == 10000 && q.size() == 0), 32'd1);

        // Flush with 7 held and 2 RAM reads in flight.
        for (int i = 0; i < 7; i++) begin
            push_one(32'h50 + W'(i));
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 32'h57;
        chk("fl_head0", out_data, 32'h50);
        step();
        in_data = 32'h58;
        chk("fl_head1", out_data, 32'h51);
        step();
        out_ready = 1'b0;
        chk("fl_pre_count", 32'(count), 32'd7);
        clear = 1'b1;
        in_data = 32'hEE;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ae", 32'(almost_empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fl_stale_valid", 32'(out_valid), 32'd0);
            chk("fl_stale_count", 32'(count), 32'd0);
        end
        push_one(32'h3C);
        pop_one("fl_new", 32'h3C);

`ifdef TEXTURE_MAPPER_FIFO_STATS_EN
        for (int i = 0; i < 9; i++) begin
            push_one(32'h60 + W'(i));
        end
        for (int i = 0; i < 7; i++) begin
            pop_one("st_drain", 32'h60 + W'(i));
        end
        for (int i = 0; i < 3; i++) begin
            push_one(32'h70 + W'(i));
        end
        chk("st_count", 32'(count), 32'd5);
        chk("st_max", 32'(max_count), 32'd9);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("st_max_clr", 32'(max_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
